// File: rtl/shift_mult_array.sv
// Array of bit-serial shift-and-add multiplier lanes behind one valid/ready stream.
// Ops are issued round-robin, retire in issue order, and may accumulate into a running sum.
module shift_mult_array #(
    parameter int A_W   = 16,
    parameter int B_W   = 4,
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    input  logic             signed_i,
    input  logic             acc_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic             busy_o
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} lane_state_t;

    lane_state_t             state     [LANES];
    logic [CNT_W-1:0]        cnt       [LANES];
    logic [A_W-1:0]          a_q       [LANES];
    logic [B_W-1:0]          b_q       [LANES];
    logic                    sgn_q     [LANES];
    logic                    acc_sel_q [LANES];
    logic signed [P_W-1:0]   prod      [LANES];
    logic signed [P_W-1:0]   shift_a   [LANES];
    logic signed [P_W-1:0]   prod_next [LANES];

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        retire_sum;
    logic                    in_fire;
    logic                    out_fire;

    function automatic logic signed [P_W-1:0] widen_a(input logic [A_W-1:0] a, input logic sgn);
        logic signed [P_W-1:0] r;
        if (sgn) r = P_W'(signed'(a));
        else     r = P_W'(a);
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] extend_p(input logic signed [P_W-1:0] p, input logic sgn);
        logic [ACC_W-1:0] r;
        if (sgn) r = ACC_W'(p);
        else     r = ACC_W'(unsigned'(p));
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LANES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o  = (state[wr_ptr] == IDLE);
    assign out_valid_o = (state[rd_ptr] == DONE);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    // Per-lane partial-product step: the top multiplier bit carries negative weight in signed mode.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            shift_a[i]   = widen_a(a_q[i], sgn_q[i]) <<< cnt[i];
            prod_next[i] = prod[i];
            if (b_q[i][cnt[i]]) begin
                if (sgn_q[i] && (cnt[i] == CNT_W'(B_W - 1))) prod_next[i] = prod[i] - shift_a[i];
                else                                          prod_next[i] = prod[i] + shift_a[i];
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (state[i] != IDLE) busy_o = 1'b1;
        end
    end

    assign retire_sum = (acc_sel_q[rd_ptr] ? acc_q : '0) + extend_p(prod[rd_ptr], sgn_q[rd_ptr]);
    assign out_data_o = out_valid_o ? retire_sum : '0;

    // Lane control, issue/retire pointers and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            acc_q  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                case (state[i])
                    IDLE: begin
                        if (in_fire && (wr_ptr == PTR_W'(i))) begin
                            state[i] <= COMPUTE;
                            cnt[i]   <= '0;
                        end
                    end
                    COMPUTE: begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                        if (cnt[i] == CNT_W'(B_W - 1)) state[i] <= DONE;
                    end
                    DONE: begin
                        if (out_fire && (rd_ptr == PTR_W'(i))) state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
            if (in_fire)  wr_ptr <= next_ptr(wr_ptr);
            if (out_fire) rd_ptr <= next_ptr(rd_ptr);
            if (acc_clr_i)     acc_q <= '0;
            else if (out_fire) acc_q <= retire_sum;
        end
    end

    // Lane operand and product registers; only meaningful while the lane is not IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (in_fire && (wr_ptr == PTR_W'(i))) begin
                a_q[i]       <= a_i;
                b_q[i]       <= b_i;
                sgn_q[i]     <= signed_i;
                acc_sel_q[i] <= acc_i;
                prod[i]      <= '0;
            end else if (state[i] == COMPUTE) begin
                prod[i] <= prod_next[i];
            end
        end
    end

endmodule
